// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bus for restoring_divider.
// master: the requester (drives start and operands); slave: the divider.
interface restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
// Optional feature macro: DIV_ZERO_DETECT_EN -- a zero divisor skips the
// iterations and reports div_by_zero with the natural all-ones result.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  restoring_divider_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH:0]  rem_r;
  logic [DW-1:0]   q_r;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] dvs_r;
  logic            busy_r;
  logic            done_r;
  logic [DW-1:0]   quo_r;
  logic [WIDTH-1:0] rem_out_r;

  logic [WIDTH:0]  r_shift;
  logic            ge;
  logic [WIDTH:0]  r_next;
  logic [DW-1:0]   q_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = {rem_r[WIDTH-1:0], q_r[DW-1]};
    ge      = (r_shift >= {1'b0, dvs_r});
    r_next  = ge ? (r_shift - {1'b0, dvs_r}) : r_shift;
    q_next  = {q_r[DW-2:0], ge};
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_r;
  assign bus.div_by_zero = dz_r;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_out_r;

  // Control FSM with datapath; results hold until the next operation's DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_r     <= '0;
      q_r       <= '0;
      cnt       <= '0;
      dvs_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      quo_r     <= '0;
      rem_out_r <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            dvs_r <= bus.divisor;
            rem_r <= '0;
            q_r   <= bus.dividend;
            cnt   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (bus.divisor == '0) begin
              state     <= DONE;
              done_r    <= 1'b1;
              quo_r     <= '1;
              rem_out_r <= bus.dividend[WIDTH-1:0];
              dz_r      <= 1'b1;
            end else
`endif
            begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_r <= r_next;
          q_r   <= q_next;
          cnt   <= cnt + 1'b1;
          // Last step: publish the result of this cycle's iteration directly.
          if (cnt == CW'(DW - 1)) begin
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            quo_r     <= q_next;
            rem_out_r <= r_next[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
            dz_r      <= 1'b0;
`endif
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
